ijvm_bus_sequencer: RTL
=======================

Name: ijvm_bus_sequencer

Overview:
- Sequences one IJVM microinstruction across the shared B/C bus register file and the memory port.
- Decodes the B-field into a one-hot b_read_enable to the bus registers and applies the C-field mask as c_write_enable.
- Issues the memory request (read / write / fetch) and waits for acknowledge with a timeout.
- Sits between the micro-sequencer (control store output) and the datapath registers.

Parameters:
- NUM_B, 9, number of B-bus source registers; bsel values at or above NUM_B are illegal.
- NUM_C, 9, number of C-bus destination registers; width of the C write mask.
- BSEL_W, 4, width of the encoded B-select field.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort; valid range 1..255.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- mi_valid  in  1  microinstruction offered.
- mi_ready  out  1  sequencer can accept; high exactly when state is IDLE.
- mi_bsel  in  BSEL_W  encoded B-bus source.
- mi_cmask  in  NUM_C  C-bus destination mask; any number of bits may be set.
- mi_mem  in  3  memory op: bit0 rd, bit1 wr, bit2 fetch.
- b_read_enable  out  NUM_B  one-hot (or zero) B-bus drive enables.
- c_write_enable  out  NUM_C  C-bus capture enables.
- mem_rd, mem_wr, mem_fetch  out  1 each  single-cycle memory request strobes.
- mem_ack  in  1  memory completion.
- busy  out  1  high when state is not IDLE.
- err_bsel  out  1  one-cycle pulse: illegal B-select accepted.
- err_mem  out  1  one-cycle pulse: rd and wr both set.
- err_timeout  out  1  one-cycle pulse: mem_ack not seen within MEM_TIMEOUT.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - All outputs 0 except mi_ready=1; state IDLE; timeout counter 0.
  - Reset mid-operation aborts immediately; no strobe or enable is held over.
- All outputs are registered except mi_ready and busy, which decode from state.
- States:
  - IDLE -> DRIVE_B on mi_valid && mi_ready. mi_bsel, mi_cmask and mi_mem are latched on acceptance; later input changes are ignored.
  - DRIVE_B (1 cycle): b_read_enable[bsel]=1, which is bus-valid from mid-cycle. If bsel >= NUM_B: b_read_enable stays 0 and err_bsel pulses in this cycle. The sequence still continues.
  - WRITE_C (1 cycle): b_read_enable held; c_write_enable = latched mask, so destinations capture on the posedge ending this cycle. The source register may also be a destination.
  - Next: MEM_REQ if latched mem != 0, else IDLE.
  - MEM_REQ (1 cycle): enables 0. Assert strobes per the latched bits; fetch may combine with rd or wr.
    - rd && wr both set: no strobes, err_mem pulses, next state IDLE.
    - Otherwise next state MEM_WAIT.
    - mem_ack during MEM_REQ is ignored.
  - MEM_WAIT: counter increments each cycle.
    - mem_ack -> IDLE.
    - Counter reaching MEM_TIMEOUT without ack -> err_timeout pulse in that cycle, then IDLE.
    - Counter clears on entry.
- Latency:
  - No-memory microinstruction: 2 busy cycles; mi_ready high again in the third cycle after acceptance.
  - Memory microinstruction: 3 + wait cycles.
- Back-to-back: a new mi_valid accepted in the first IDLE cycle gives no bubble beyond IDLE.
- b_read_enable is never multi-hot. c_write_enable and b_read_enable are 0 outside DRIVE_B/WRITE_C.

Test Plan:
- Reset held 3 cycles with mi_valid=1 -> all outputs 0, mi_ready=1, nothing accepted; release, mi_bsel=4, mi_cmask=0x005, mi_mem=0 -> b_read_enable=0x010 for 2 cycles, c_write_enable=0x005 in 2nd cycle only, mi_ready back in cycle 3.
- mi_bsel=2, mi_cmask=0x004 (same register), mi_mem=rd, mem_ack 3 cycles after mem_rd -> one-cycle mem_rd pulse, busy until cycle after ack, no err.
- mi_bsel=12 (NUM_B=9) -> b_read_enable stays 0, err_bsel one pulse during DRIVE_B, c_write_enable still applied.
- mi_mem=3'b011 -> no mem_rd/mem_wr, err_mem one pulse, returns IDLE after MEM_REQ.
- mi_mem=wr, mem_ack never asserted, MEM_TIMEOUT=15 -> err_timeout pulses on the 15th MEM_WAIT cycle, then IDLE; mem_ack asserted in MEM_REQ only -> ignored, timeout still occurs.
- Reset asserted during MEM_WAIT -> next cycle IDLE, all strobes/enables 0; mi_valid pulses mid-sequence -> ignored, latched fields unchanged.

Source files
------------

// File: rtl/ijvm_bus_sequencer.sv
// ijvm_bus_sequencer: steps one IJVM microinstruction through the B-bus drive,
// the C-bus write-back and an optional memory request with an ack timeout.
module ijvm_bus_sequencer #(
    parameter int unsigned NUM_B       = 9,
    parameter int unsigned NUM_C       = 9,
    parameter int unsigned BSEL_W      = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mi_valid,
    output logic              mi_ready,
    input  logic [BSEL_W-1:0] mi_bsel,
    input  logic [NUM_C-1:0]  mi_cmask,
    input  logic [2:0]        mi_mem,
    output logic [NUM_B-1:0]  b_read_enable,
    output logic [NUM_C-1:0]  c_write_enable,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_fetch,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err_bsel,
    output logic              err_mem,
    output logic              err_timeout
);

    // Wait counter is sized for the largest legal timeout (255).
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE_B,
        S_WRITE_C,
        S_MEM_REQ,
        S_MEM_WAIT
    } state_t;

    state_t            state;
    logic [NUM_C-1:0]  cmask_q;
    logic [2:0]        mem_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [NUM_B-1:0]  b_dec;
    logic              bsel_bad;
    logic              mem_conflict;

    // Handshake and activity flags decode straight from state.
    assign mi_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // rd and wr together is an illegal memory op.
    assign mem_conflict = mem_q[0] & mem_q[1];

    // One-hot decode of the offered B-select; out-of-range selects decode to zero.
    always_comb begin
        b_dec    = '0;
        bsel_bad = (32'(mi_bsel) >= NUM_B);
        for (int unsigned i = 0; i < NUM_B; i++) begin
            if (32'(mi_bsel) == i) begin
                b_dec[i] = 1'b1;
            end
        end
    end

    // Sequencer FSM; every output is produced one cycle ahead so it is registered
    // and valid for the whole cycle of the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cmask_q        <= '0;
            mem_q          <= '0;
            wait_cnt       <= '0;
            b_read_enable  <= '0;
            c_write_enable <= '0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_fetch      <= 1'b0;
            err_bsel       <= 1'b0;
            err_mem        <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            // Strobes and error flags are single-cycle pulses.
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_fetch   <= 1'b0;
            err_bsel    <= 1'b0;
            err_mem     <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    b_read_enable  <= '0;
                    c_write_enable <= '0;
                    wait_cnt       <= '0;
                    if (mi_valid) begin
                        state         <= S_DRIVE_B;
                        cmask_q       <= mi_cmask;
                        mem_q         <= mi_mem;
                        b_read_enable <= b_dec;
                        err_bsel      <= bsel_bad;
                    end
                end

                S_DRIVE_B: begin
                    // Source keeps driving while destinations capture.
                    c_write_enable <= cmask_q;
                    state          <= S_WRITE_C;
                end

                S_WRITE_C: begin
                    b_read_enable  <= '0;
                    c_write_enable <= '0;
                    if (mem_q != 3'b000) begin
                        state <= S_MEM_REQ;
                        if (mem_conflict) begin
                            err_mem <= 1'b1;
                        end else begin
                            mem_rd    <= mem_q[0];
                            mem_wr    <= mem_q[1];
                            mem_fetch <= mem_q[2];
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_MEM_REQ: begin
                    // An ack arriving alongside the request is not counted.
                    wait_cnt <= '0;
                    if (mem_conflict) begin
                        state <= S_IDLE;
                    end else begin
                        state       <= S_MEM_WAIT;
                        err_timeout <= (MEM_TIMEOUT == 1);
                    end
                end

                S_MEM_WAIT: begin
                    // wait_cnt holds the number of wait cycles already completed.
                    if (mem_ack || (wait_cnt == LAST_WAIT)) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt    <= wait_cnt + CNT_W'(1);
                        err_timeout <= ((wait_cnt + CNT_W'(1)) == LAST_WAIT);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
